regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised RV GPR file for the pipelined core: NRP combinational read ports, one write port,
//  same-cycle write-to-read bypass, hardwired x0, and a per-register busy scoreboard.
//  Sits between decode (reads, issue) and writeback. Replaces the fixed 2-read, 32x32 file.
//  Adds async reset, RAW hazard detection, WAW issue blocking and flush.
// PARAMETERS
//  XLEN   32                   data width in bits
//  NREGS  32                   number of GPRs (16 for RV32E); x0 is always index 0
//  NRP    2                    number of read ports (>=1)
//  AW     $clog2(NREGS)        register address width (derived; do not override)
//  CW     $clog2(NREGS+1)      busy_count width (derived)
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         async active-low reset
//  rd_addr      in   NRP*AW    read addresses; port p = [p*AW +: AW]
//  rd_data      out  NRP*XLEN  read data; port p = [p*XLEN +: XLEN]
//  rd_busy      out  NRP       port p operand not yet available (RAW hazard)
//  issue_valid  in   1         decode issues an instr writing issue_rd
//  issue_rd     in   AW        destination of the issuing instr
//  issue_ready  out  1         issue_rd may be claimed this cycle
//  wb_en        in   1         writeback strobe
//  wb_addr      in   AW        writeback destination
//  wb_data      in   XLEN      writeback data
//  flush        in   1         sync clear of all busy bits (branch mispredict/trap)
//  busy_count   out  CW        number of busy registers
// BEHAVIOUR
//  - Reset (rst_n=0, async): all GPRs=0, all busy=0, busy_count=0. Outputs are combinational
//    from that state: rd_data=0 and rd_busy=0, except where bypass applies (see Reads).
//  - x0: always reads 0, never busy. Writes to x0 are discarded. Issue to x0 is always ready
//    and sets no bit.
//  - Reads (0-cycle, comb):
//    - if wb_en & wb_addr==rd_addr[p] & rd_addr[p]!=0: rd_data[p]=wb_data (bypass).
//    - otherwise rd_data[p]=gpr[rd_addr[p]].
//  - rd_busy[p] = busy[rd_addr[p]] & ~(wb_en & wb_addr==rd_addr[p]). A value arriving this cycle
//    counts as available.
//  - Write: on posedge with wb_en & wb_addr!=0, gpr[wb_addr]<=wb_data. 1-cycle write latency;
//    the bypass hides it.
//  - issue_ready = (issue_rd==0) | ~busy[issue_rd] | (wb_en & wb_addr==issue_rd). Blocks a second
//    outstanding write (WAW). issue_ready is independent of issue_valid. Issue with issue_ready=0
//    is ignored (no state change); decode must stall.
//  - Busy update on posedge, priority high->low:
//    - flush: all busy<=0; issue and wb clears this cycle are ignored. The GPR write still occurs.
//    - accepted issue (issue_valid & issue_ready & issue_rd!=0): busy[issue_rd]<=1. Wins over a
//      same-cycle wb to the same reg: the new producer owns it.
//    - wb_en & wb_addr!=0: busy[wb_addr]<=0.
//    - Issue and wb to different regs: both take effect.
//  - busy_count: registered popcount of the next busy vector, updated in the same edge. Never
//    exceeds NREGS-1. flush -> 0 next cycle.
//  - wb to a non-busy reg is legal: data written, busy unchanged.
//  - Out-of-range addresses (>=NREGS, when NREGS is not a power of 2): read 0, writes/issues
//    ignored, issue_ready=1.
// STRUCTURE
//  - Package regfile_pkg: XLEN/NREGS defaults, REG_ZERO=0, helper function clog2, type for the
//    busy vector.
//  - Sub-module regfile_read_port: one per read port, via generate over NRP.
//    - Inputs: addr, gpr array slice, busy vector, wb bypass.
//    - Outputs: rd_data, rd_busy.
//  - Top level holds the GPR array, busy vector, busy_count register and update priority logic.
// TESTING
//  - Reset mid-run: write x5=0xDEADBEEF, issue x6, assert rst_n=0 -> rd x5=0, busy_count=0,
//    rd_busy=0 immediately (before next clk edge).
//  - x0: wb_en x0=0xFFFFFFFF, issue x0 -> reading x0 gives 0, rd_busy=0, busy_count unchanged.
//  - Bypass: wb x7=0x12345678 with rd_addr[1]=7 in the same cycle -> rd_data[1]=0x12345678,
//    rd_busy[1]=0. Next cycle, with wb_en=0 -> still 0x12345678.
//  - Scoreboard:
//    - issue x3 -> next cycle rd_busy=1 on port reading x3, busy_count=1, issue_ready(x3)=0.
//    - wb x3=0xA5 -> that cycle rd_data=0xA5, rd_busy=0; next cycle busy_count=0.
//  - Simultaneous issue+wb to x9 while x9 busy: issue_ready=1 -> after the edge gpr[9]=wb_data,
//    busy[9]=1, busy_count unchanged.
//  - Flush:
//    - busy x1, x2, x4; flush with issue x8 and wb x10=0x55 -> next cycle busy_count=0, x8 not
//      busy, x10 reads 0x55.
//    - Sweep NRP=3, NREGS=16 for all tests.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults, constants and types for the GPR file.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int MAX_NREGS = 32;
    localparam int REG_ZERO  = 0;

    // Sized for the largest file; smaller files leave the upper bits at zero.
    typedef logic [MAX_NREGS-1:0] busy_vec_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : One combinational GPR read port with writeback bypass and
//                RAW busy indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = clog2(NREGS)
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] gpr [NREGS],
    input  busy_vec_t       busy,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_busy
);

    logic w_in_range;
    logic w_hit;

    assign w_in_range = ({1'b0, addr} < (AW+1)'(NREGS));
    assign w_hit      = wb_en && (wb_addr == addr);

    always_comb begin
        rd_data = '0;
        if (w_in_range) begin
            if (w_hit && (addr != AW'(REG_ZERO)))
                rd_data = wb_data;
            else
                rd_data = gpr[addr];
        end
    end

    // A value landing this cycle already satisfies the reader.
    assign rd_busy = busy[addr] && !w_hit;

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Multi-read-port GPR file with write bypass, hardwired x0 and
//                a per-register busy scoreboard with flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRP   = 2,
    parameter int AW    = clog2(NREGS),
    parameter int CW    = clog2(NREGS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [CW-1:0]       busy_count
);

    logic [XLEN-1:0]  r_gpr [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [CW-1:0]    r_busy_count;

    logic [NREGS-1:0] w_busy_nxt;
    logic [CW-1:0]    w_count_nxt;
    busy_vec_t        w_busy_ext;
    logic             w_wb_we;
    logic             w_issue_acc;
    logic             w_wb_in_range;
    logic             w_issue_in_range;

    assign w_wb_in_range    = ({1'b0, wb_addr}  < (AW+1)'(NREGS));
    assign w_issue_in_range = ({1'b0, issue_rd} < (AW+1)'(NREGS));
    assign w_wb_we          = wb_en && (wb_addr != AW'(REG_ZERO)) && w_wb_in_range;

    assign issue_ready = (issue_rd == AW'(REG_ZERO)) || !w_issue_in_range ||
                         !r_busy[issue_rd] || (wb_en && (wb_addr == issue_rd));
    assign w_issue_acc = issue_valid && issue_ready &&
                         (issue_rd != AW'(REG_ZERO)) && w_issue_in_range;

    // Issue is applied after the writeback clear so the new producer keeps ownership.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (w_wb_we)     w_busy_nxt[wb_addr]  = 1'b0;
            if (w_issue_acc) w_busy_nxt[issue_rd] = 1'b1;
        end
    end

    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            w_count_nxt = w_count_nxt + CW'(w_busy_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wb_we) r_gpr[wb_addr] <= wb_data;
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_count_nxt;
        end
    end

    assign busy_count = r_busy_count;
    assign w_busy_ext = busy_vec_t'(r_busy);

    generate
        for (genvar p = 0; p < NRP; p++) begin : g_rd_port
            regfile_read_port #(
                .XLEN  (XLEN),
                .NREGS (NREGS),
                .AW    (AW)
            ) u_rd_port (
                .addr    (rd_addr[p*AW +: AW]),
                .gpr     (r_gpr),
                .busy    (w_busy_ext),
                .wb_en   (wb_en),
                .wb_addr (wb_addr),
                .wb_data (wb_data),
                .rd_data (rd_data[p*XLEN +: XLEN]),
                .rd_busy (rd_busy[p])
            );
        end
    endgenerate

endmodule
`default_nettype wire
